dmem_arbiter: RTL



---
 rtl/dmem_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the pipeline MEM stage (P) and a debug/DMA loader (D).
// Optional D starvation guard is compiled in by defining DMEM_ARB_STARVE_GUARD_EN.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p_req_i,
  input  logic              p_we_i,
  input  logic [ADDR_W-1:0] p_addr_i,
  input  logic [DATA_W-1:0] p_wdata_i,
  input  logic              halted_flag_i,
  output logic              p_gnt_o,
  output logic              p_stall_o,
  output logic              p_rvalid_o,
  output logic [DATA_W-1:0] p_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  // Handshake: a requester holds req with a stable command until it sees gnt in
  // the same cycle; gnt means memory took the command that cycle. A granted read
  // returns its data with a one-cycle rvalid pulse on the following cycle, and the
  // return path has no backpressure.

  logic pv;
  logic p_gnt;
  logic d_gnt;
  logic p_stall;

  assign pv = p_req_i & ~halted_flag_i;

`ifdef DMEM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             force_d;

  assign force_d = (starve_cnt == CNT_W'(STARVE_LIMIT));

  always_comb begin
    p_gnt   = 1'b0;
    d_gnt   = 1'b0;
    p_stall = 1'b0;
    if (!rst) begin
      if (force_d) begin
        // D has waited long enough: it takes this cycle even against P.
        d_gnt   = d_req_i;
        p_stall = pv;
      end else begin
        p_gnt = pv;
        d_gnt = d_req_i & ~pv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !d_req_i || d_gnt) begin
      starve_cnt <= '0;
    end else if (!force_d) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = (STARVE_LIMIT > 0);

  always_comb begin
    p_gnt   = ~rst & pv;
    d_gnt   = ~rst & d_req_i & ~pv;
    p_stall = 1'b0;
  end
`endif

  assign p_gnt_o   = p_gnt;
  assign d_gnt_o   = d_gnt;
  assign p_stall_o = p_stall;

  // Memory lines idle at zero when nobody is granted, so a write can never leak out.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (p_gnt) begin
      mem_we_o    = p_we_i;
      mem_addr_o  = p_addr_i;
      mem_wdata_o = p_wdata_i;
    end else if (d_gnt) begin
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_rvalid_o <= 1'b0;
      d_rvalid_o <= 1'b0;
      p_rdata_o  <= '0;
      d_rdata_o  <= '0;
    end else begin
      p_rvalid_o <= p_gnt & ~p_we_i;
      d_rvalid_o <= d_gnt & ~d_we_i;
      if (p_gnt && !p_we_i) begin
        p_rdata_o <= mem_rdata_i;
      end
      if (d_gnt && !d_we_i) begin
        d_rdata_o <= mem_rdata_i;
      end
    end
  end

endmodule
